// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: clamps a fill command to the 640x480 frame and streams
// one colour write per covered pixel into the frame buffer write port.
module fb_rect_fill #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x0,
  input  logic [8:0]        cmd_y0,
  input  logic [9:0]        cmd_x1,
  input  logic [8:0]        cmd_y1,
  input  logic [DATA_W-1:0] cmd_color,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [DATA_W-1:0] fb_wdata,
  input  logic              fb_wready,
  output logic              busy,
  output logic              done
);

  localparam logic [9:0]        X_MAX    = 10'(H_RES - 1);
  localparam logic [8:0]        Y_MAX    = 9'(V_RES - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t state, next_state;

  logic [9:0]        x0_q, x1_q, col;
  logic [8:0]        y0_q, y1_q, row;
  logic [DATA_W-1:0] color_q;
  logic [ADDR_W-1:0] row_base;

  logic [9:0]        x0_c, x1_c;
  logic [8:0]        y0_c, y1_c;
  logic [ADDR_W-1:0] y0_wide, setup_base;
  logic              empty;
  logic              accept, wr_done, col_last, row_last;

  always_ff @(posedge CLK100MHZ) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   next_state = empty ? DONE : FILL;
      FILL:    if (wr_done && col_last && row_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    accept    = cmd_valid && cmd_ready;
    wr_done   = fb_we && fb_wready;
    col_last  = (col >= x1_q);
    row_last  = (row >= y1_q);
  end

  // Clamp to the visible frame; row_base = 640*y0 built from shifts (512 + 128).
  always_comb begin
    x0_c       = (x0_q > X_MAX) ? X_MAX : x0_q;
    x1_c       = (x1_q > X_MAX) ? X_MAX : x1_q;
    y0_c       = (y0_q > Y_MAX) ? Y_MAX : y0_q;
    y1_c       = (y1_q > Y_MAX) ? Y_MAX : y1_q;
    empty      = (x0_c > x1_c) || (y0_c > y1_c);
    y0_wide    = ADDR_W'(y0_c);
    setup_base = (y0_wide << 9) + (y0_wide << 7);
  end

  // The first FILL cycle only loads the write registers; afterwards each
  // accepted write loads the next pixel so throughput stays one per cycle.
  always_ff @(posedge CLK100MHZ) begin
    if (!rst) begin
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      col      <= '0;
      row      <= '0;
      color_q  <= '0;
      row_base <= '0;
      fb_we    <= 1'b0;
      fb_waddr <= '0;
      fb_wdata <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            x0_q    <= cmd_x0;
            x1_q    <= cmd_x1;
            y0_q    <= cmd_y0;
            y1_q    <= cmd_y1;
            color_q <= cmd_color;
            busy    <= 1'b1;
          end
        end
        SETUP: begin
          x0_q     <= x0_c;
          x1_q     <= x1_c;
          y0_q     <= y0_c;
          y1_q     <= y1_c;
          col      <= x0_c;
          row      <= y0_c;
          row_base <= setup_base;
        end
        FILL: begin
          if (!fb_we) begin
            fb_we    <= 1'b1;
            fb_waddr <= row_base + ADDR_W'(col);
            fb_wdata <= color_q;
          end else if (wr_done) begin
            if (!col_last) begin
              col      <= col + 10'd1;
              fb_waddr <= fb_waddr + ADDR_W'(1);
            end else if (!row_last) begin
              col      <= x0_q;
              row      <= row + 9'd1;
              row_base <= row_base + ROW_STEP;
              fb_waddr <= row_base + ROW_STEP + ADDR_W'(x0_q);
            end else begin
              fb_we <= 1'b0;
            end
          end
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: a reference model queues expected writes per
// command and a negedge monitor pops and compares every completed write.
module tb_fb_rect_fill;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        cmd_x0, cmd_x1;
  logic [8:0]        cmd_y0, cmd_y1;
  logic [DATA_W-1:0] cmd_color;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_waddr;
  logic [DATA_W-1:0] fb_wdata;
  logic              fb_wready;
  logic              busy;
  logic              done;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cnt, stall_cnt, done_cnt, exp_writes;
  int acc_cyc, first_we_cyc, done_cyc;
  logic              hold_valid = 1'b0;
  logic [ADDR_W-1:0] held_addr;
  logic [DATA_W-1:0] held_data;

  fb_rect_fill dut (
    .CLK100MHZ(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0),
    .cmd_y0(cmd_y0),
    .cmd_x1(cmd_x1),
    .cmd_y1(cmd_y1),
    .cmd_color(cmd_color),
    .fb_we(fb_we),
    .fb_waddr(fb_waddr),
    .fb_wdata(fb_wdata),
    .fb_wready(fb_wready),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: writes complete where fb_we && fb_wready; stalled writes must hold.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (fb_we) begin
        if (first_we_cyc < 0) first_we_cyc = cyc;
        if (hold_valid) begin
          checkOutput("stall_addr_hold", 32'(fb_waddr), 32'(held_addr));
          checkOutput("stall_data_hold", 32'(fb_wdata), 32'(held_data));
        end
        if (fb_wready) begin
          hold_valid = 1'b0;
          checkOutput("write_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            wr_t e;
            e = exp_q.pop_front();
            checkOutput("write_addr", 32'(fb_waddr), 32'(e.addr));
            checkOutput("write_data", 32'(fb_wdata), 32'(e.data));
          end
          wr_cnt++;
        end else begin
          stall_cnt++;
          hold_valid = 1'b1;
          held_addr  = fb_waddr;
          held_data  = fb_wdata;
        end
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  // Queues the model's writes for one command, then performs the handshake.
  task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                               input logic [DATA_W-1:0] color);
    int cx0, cx1, cy0, cy1, n;
    cx0 = (x0 > 639) ? 639 : x0;
    cx1 = (x1 > 639) ? 639 : x1;
    cy0 = (y0 > 479) ? 479 : y0;
    cy1 = (y1 > 479) ? 479 : y1;
    exp_writes = 0;
    for (int r = cy0; r <= cy1; r++)
      for (int c = cx0; c <= cx1; c++) begin
        exp_q.push_back('{addr: ADDR_W'(r * 640 + c), data: color});
        exp_writes++;
      end
    wr_cnt       = 0;
    stall_cnt    = 0;
    done_cnt     = 0;
    first_we_cyc = -1;
    done_cyc     = -1;
    cmd_x0       = 10'(x0);
    cmd_y0       = 9'(y0);
    cmd_x1       = 10'(x1);
    cmd_y1       = 9'(y1);
    cmd_color    = color;
    cmd_valid    = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("handshake_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int limit, input bit alt);
    int n;
    n = 0;
    while (done_cnt == 0 && n < limit) begin
      @(posedge clk); #1;
      if (alt) fb_wready = ~fb_wready;
      n++;
    end
    fb_wready = 1'b1;
    checkOutput("done_seen", 32'(done_cnt > 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkFill(input string tag);
    checkOutput({tag, "_writes"}, 32'(wr_cnt), 32'(exp_writes));
    checkOutput({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    if (exp_writes == 0)
      checkOutput({tag, "_done_latency"}, 32'(done_cyc - acc_cyc), 32'd2);
    else begin
      checkOutput({tag, "_first_write_latency"}, 32'(first_we_cyc - acc_cyc), 32'd2);
      checkOutput({tag, "_done_latency"}, 32'(done_cyc - acc_cyc), 32'(3 + exp_writes + stall_cnt));
    end
    checkOutput({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0    = '0;
    cmd_y0    = '0;
    cmd_x1    = '0;
    cmd_y1    = '0;
    cmd_color = '0;
    fb_wready = 1'b1;
    done_cnt  = 0;
    first_we_cyc = -1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_we", 32'(fb_we), 32'd0);
    checkOutput("reset_waddr", 32'(fb_waddr), 32'd0);
    checkOutput("reset_wdata", 32'(fb_wdata), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single pixel");
    applyStimulus(5, 2, 5, 2, 12'hF00);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("ready_low_busy", 32'(cmd_ready), 32'd0);
    waitDone(50, 1'b0);
    checkFill("single");

    $display("[TB] right-edge clamp");
    applyStimulus(638, 0, 640, 1, 12'h0F0);
    waitDone(50, 1'b0);
    checkFill("clamp_x");

    $display("[TB] backpressure");
    applyStimulus(100, 10, 103, 10, 12'hABC);
    waitDone(100, 1'b1);
    checkFill("stall");
    checkOutput("stall_seen", 32'(stall_cnt > 0), 32'd1);

    $display("[TB] empty command");
    applyStimulus(10, 5, 3, 8, 12'h777);
    waitDone(50, 1'b0);
    checkFill("empty");

    $display("[TB] bottom band with clamped corner");
    applyStimulus(0, 478, 1023, 511, 12'h123);
    waitDone(2000, 1'b0);
    checkFill("bottom_band");
    checkOutput("last_addr", 32'(fb_waddr), 32'd307199);

    $display("[TB] reset mid-fill");
    applyStimulus(0, 100, 99, 100, 12'h555);
    n = 0;
    while (wr_cnt < 50 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("reached_write_50", 32'(wr_cnt >= 50), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_we", 32'(fb_we), 32'd0);
    checkOutput("abort_ready", 32'(cmd_ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    done_cnt = 0;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
    checkOutput("abort_no_writes", 32'(fb_we), 32'd0);

    $display("[TB] fill after reset");
    applyStimulus(50, 60, 51, 61, 12'h9A5);
    waitDone(50, 1'b0);
    checkFill("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
